pc_gen: RTL
===========

Name: pc_gen

Overview:
Registered program-counter generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. Each cycle it selects the next fetch address. Selection priority is: execute-stage redirect, then stall hold, then predicted-taken target, then sequential increment. It sits at the front of the fetch stage. Execute-stage branch resolution trains it through a dedicated update port.

Parameters:
XLEN, 32, address/data width in bits
BTB_ENTRIES, 16, number of BTB entries; power of two, minimum 2
RESET_ADDR, 32'h0000_0000, PC value loaded on reset
PC_INC, 4, sequential increment in bytes

Ports:
clock_in  input  1  system clock, all state updates on rising edge
reset_n_in  input  1  asynchronous active-low reset
pc_gen_stall_in  input  1  hold current PC (fetch not ready)
pc_gen_redirect_en_in  input  1  execute-stage redirect (mispredict, jump, trap)
pc_gen_redirect_addr_in  input  XLEN  redirect target address
pc_gen_update_en_in  input  1  resolved branch training strobe
pc_gen_update_pc_in  input  XLEN  address of the resolved branch
pc_gen_update_target_in  input  XLEN  resolved target address
pc_gen_update_taken_in  input  1  resolved direction, 1 = taken
pc_gen_pc_out  output  XLEN  current fetch address (registered)
pc_gen_valid_out  output  1  pc_gen_pc_out is a valid fetch request
pc_gen_pred_taken_out  output  1  prediction made for pc_gen_pc_out (combinational)
pc_gen_pred_target_out  output  XLEN  predicted target for pc_gen_pc_out (combinational)

Behaviour:
- Reset (asynchronous assert, synchronous release by clock edge):
  - pc_gen_pc_out = RESET_ADDR; pc_gen_valid_out = 0.
  - All BTB valid bits = 0; all counters = 2'b01.
  - Reset asserted mid-operation discards any pending redirect or update.
- Valid: pc_gen_valid_out rises to 1 on the first rising edge after reset release. It then stays 1 until the next reset.
- BTB addressing (IDX = log2(BTB_ENTRIES)):
  - index = pc[IDX+1:2].
  - tag = pc[XLEN-1:IDX+2].
  - Each entry holds valid, tag, target[XLEN-1:0] and ctr[1:0].
- Lookup (combinational, on pc_gen_pc_out):
  - hit = entry.valid AND tag match.
  - pc_gen_pred_taken_out = hit AND ctr[1].
  - pc_gen_pred_target_out = entry.target when hit, else pc_gen_pc_out + PC_INC.
  - Lookup returns 0 / sequential address while valid_out = 0.
- Next-PC priority, applied at each rising edge:
  1. redirect_en = 1: PC <= redirect_addr. Overrides stall.
  2. stall = 1: PC holds.
  3. pred_taken = 1: PC <= pred_target.
  4. Otherwise: PC <= PC + PC_INC, modulo 2^XLEN. 32'hFFFF_FFFC + 4 wraps to 0.
- Next-PC latency: exactly one cycle from redirect_en to the new pc_gen_pc_out.
- Update (registered, takes effect at the edge where update_en = 1):
  - Tag hit, taken: ctr saturating increment (max 2'b11); target <= update_target.
  - Tag hit, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate/replace the entry. valid = 1, tag written, target written, ctr = 2'b10.
  - Miss, not taken: no change.
- Update and lookup in the same cycle, same index: lookup sees pre-update contents. The new contents are visible from the next cycle.
- Simultaneous redirect and update: both performed. Update is independent of the PC path.
- Update and stall are independent. Training proceeds while stalled.
- Update address bits [1:0] are ignored.

Test Plan:
- Reset: hold reset_n_in = 0, RESET_ADDR = 0x100, then release. Required: pc_out = 0x100 with valid = 0 before the first edge; valid = 1 after the first edge; pc sequence 0x100, 0x104, 0x108; pred_taken = 0 throughout.
- Stall vs redirect: stall = 1 for 3 cycles at pc 0x20; assert redirect_en = 1, addr = 0x400 during the stall. Required: pc holds 0x20, then becomes 0x400 the cycle after redirect, despite stall.
- Train and predict: update (pc 0x40, target 0x80, taken). Run sequentially from 0x30. Required: at pc 0x40, pred_taken = 1 and pred_target = 0x80; next pc = 0x80.
- Counter saturation: two taken updates, then three not-taken updates at 0x40. Required: ctr 10 -> 11 -> 11 -> 10 -> 01 -> 00. pred_taken = 0 after the second not-taken; next pc from 0x40 is 0x44.
- Aliasing and tag: BTB_ENTRIES = 16; train 0x40 -> 0x80. Required: fetching 0x440 (same index, different tag) gives pred_taken = 0. A taken update at 0x440 with target 0x900 replaces the entry; 0x40 then misses.
- Wrap and same-cycle update: PC = 0xFFFF_FFFC, no hit. Required: next pc = 0x0000_0000. An update to the current PC's index in the same cycle does not change that cycle's pred_taken.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-front interface: stall/redirect/training inputs and the registered fetch PC with its prediction.
// Signal names keep the block's published port names so integration scripts can match them directly.
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            pc_gen_stall_in;
  logic            pc_gen_redirect_en_in;
  logic [XLEN-1:0] pc_gen_redirect_addr_in;
  logic            pc_gen_update_en_in;
  logic [XLEN-1:0] pc_gen_update_pc_in;
  logic [XLEN-1:0] pc_gen_update_target_in;
  logic            pc_gen_update_taken_in;
  logic [XLEN-1:0] pc_gen_pc_out;
  logic            pc_gen_valid_out;
  logic            pc_gen_pred_taken_out;
  logic [XLEN-1:0] pc_gen_pred_target_out;

  modport master (
    output pc_gen_stall_in, pc_gen_redirect_en_in, pc_gen_redirect_addr_in,
           pc_gen_update_en_in, pc_gen_update_pc_in, pc_gen_update_target_in,
           pc_gen_update_taken_in,
    input  pc_gen_pc_out, pc_gen_valid_out, pc_gen_pred_taken_out, pc_gen_pred_target_out
  );

  modport slave (
    input  pc_gen_stall_in, pc_gen_redirect_en_in, pc_gen_redirect_addr_in,
           pc_gen_update_en_in, pc_gen_update_pc_in, pc_gen_update_target_in,
           pc_gen_update_taken_in,
    output pc_gen_pc_out, pc_gen_valid_out, pc_gen_pred_taken_out, pc_gen_pred_target_out
  );
endinterface

// File: rtl/pc_gen.sv
// Next-fetch PC generator with direct-mapped BTB and 2-bit counters; redirect lands one cycle later.
// Stall holds the PC (redirect still wins); BTB training never stalls and is independent of the PC path.
module pc_gen #(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int              PC_INC      = 4
) (
  input logic    clock_in,
  input logic    reset_n_in,
  pc_gen_if.slave bus
);
  localparam int IDX  = $clog2(BTB_ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;

  typedef logic [IDX-1:0]  idx_t;
  typedef logic [TAGW-1:0] tag_t;

  typedef struct packed {
    logic            vld;
    tag_t            tag;
    logic [XLEN-1:0] tgt;
    logic [1:0]      ctr;
  } btb_entry_t;

  logic [XLEN-1:0] pc_q;
  logic            valid_q;
  btb_entry_t      btb_q [BTB_ENTRIES];

  idx_t            lk_idx;
  btb_entry_t      lk_ent;
  logic            lk_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [XLEN-1:0] pc_seq;
  logic [XLEN-1:0] pc_nxt;

  idx_t            up_idx;
  tag_t            up_tag;
  btb_entry_t      up_ent;
  btb_entry_t      up_new;
  logic            up_hit;
  logic            unused_up_low;

  // Predictions are suppressed until the first fetch is valid.
  always_comb begin
    lk_idx      = pc_q[IDX+1:2];
    lk_ent      = btb_q[lk_idx];
    lk_hit      = valid_q && lk_ent.vld && (lk_ent.tag == pc_q[XLEN-1:IDX+2]);
    pc_seq      = pc_q + XLEN'(PC_INC);
    pred_taken  = lk_hit && lk_ent.ctr[1];
    pred_target = lk_hit ? lk_ent.tgt : pc_seq;
  end

  always_comb begin
    pc_nxt = pc_q;
    if (bus.pc_gen_redirect_en_in) begin
      pc_nxt = bus.pc_gen_redirect_addr_in;
    end else if (!valid_q || bus.pc_gen_stall_in) begin
      pc_nxt = pc_q;
    end else if (pred_taken) begin
      pc_nxt = pred_target;
    end else begin
      pc_nxt = pc_seq;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      pc_q    <= RESET_ADDR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_nxt;
      valid_q <= 1'b1;
    end
  end

  assign unused_up_low = ^bus.pc_gen_update_pc_in[1:0];

  always_comb begin
    up_idx = bus.pc_gen_update_pc_in[IDX+1:2];
    up_tag = bus.pc_gen_update_pc_in[XLEN-1:IDX+2];
    up_ent = btb_q[up_idx];
    up_hit = up_ent.vld && (up_ent.tag == up_tag);
    up_new = up_ent;
    if (up_hit) begin
      if (bus.pc_gen_update_taken_in) begin
        if (up_ent.ctr != 2'b11) up_new.ctr = up_ent.ctr + 2'd1;
        up_new.tgt = bus.pc_gen_update_target_in;
      end else if (up_ent.ctr != 2'b00) begin
        up_new.ctr = up_ent.ctr - 2'd1;
      end
    end else if (bus.pc_gen_update_taken_in) begin
      up_new = '{vld: 1'b1, tag: up_tag, tgt: bus.pc_gen_update_target_in, ctr: 2'b10};
    end
  end

  // Written at the edge, so a same-cycle lookup still sees the old entry.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{vld: 1'b0, tag: '0, tgt: '0, ctr: 2'b01};
      end
    end else if (bus.pc_gen_update_en_in) begin
      btb_q[up_idx] <= up_new;
    end
  end

  assign bus.pc_gen_pc_out          = pc_q;
  assign bus.pc_gen_valid_out       = valid_q;
  assign bus.pc_gen_pred_taken_out  = pred_taken;
  assign bus.pc_gen_pred_target_out = pred_target;
endmodule
